// File: rtl/axis_frame_pattern_gen_if.sv
// AXI4-Stream beat bus for the frame pattern generator.
// The master drives valid/data/strobe/last, and the slave drives ready.
interface axis_frame_pattern_gen_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_frame_pattern_gen.sv
// AXI4-Stream test-frame source: launches fixed-length patterned frames on a
// programmable period while START is high, with frame and overrun statistics.
module axis_frame_pattern_gen #(
  parameter int DATA_WIDTH    = 32,
  parameter int FRAME_BEATS   = 4096,
  parameter int PERIOD_CYCLES = 5900,
  parameter int INIT_VALUE    = 4,
  parameter int FRAME_STEP    = 2,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                      M_AXIS_ACLK,
  input  logic                      M_AXIS_ARESET,
  input  logic                      START,
  input  logic [1:0]                MODE,
  axis_frame_pattern_gen_if.master  m_axis,
  output logic                      BUSY,
  output logic [STAT_WIDTH-1:0]     FRAME_COUNT,
  output logic [STAT_WIDTH-1:0]     MISSED_COUNT
);

  localparam int BEAT_W  = $clog2(FRAME_BEATS);
  localparam int TIMER_W = $clog2(PERIOD_CYCLES);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(FRAME_BEATS - 1);
  localparam logic [TIMER_W-1:0] LAST_TICK  = TIMER_W'(PERIOD_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] BASE_INIT = DATA_WIDTH'(INIT_VALUE);
  localparam logic [DATA_WIDTH-1:0] BASE_STEP = DATA_WIDTH'(FRAME_STEP);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [DATA_WIDTH-1:0]  base_q;
  logic [1:0]             mode_q;

  logic tick, xfer, last_xfer, launch;

  always_comb begin
    tick      = START && (timer_q == '0);
    xfer      = (state_q == SEND) && m_axis.tready;
    last_xfer = xfer && (beat_q == LAST_BEAT);
    // A tick coinciding with the completing beat relaunches straight away.
    launch    = tick && ((state_q == IDLE) || last_xfer);
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET || !START) begin
      timer_q <= '0;
    end else if (timer_q == LAST_TICK) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (tick) state_d = SEND;
      SEND: if (last_xfer && !tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      beat_q       <= '0;
      base_q       <= BASE_INIT;
      mode_q       <= '0;
      FRAME_COUNT  <= '0;
      MISSED_COUNT <= '0;
    end else begin
      if (launch) begin
        beat_q <= '0;
        mode_q <= MODE;
      end else if (xfer) begin
        beat_q <= beat_q + BEAT_W'(1);
      end

      if (last_xfer) begin
        base_q <= base_q + BASE_STEP;
        if (FRAME_COUNT != '1) FRAME_COUNT <= FRAME_COUNT + STAT_WIDTH'(1);
      end

      if (tick && (state_q == SEND) && !last_xfer && (MISSED_COUNT != '1)) begin
        MISSED_COUNT <= MISSED_COUNT + STAT_WIDTH'(1);
      end
    end
  end

  // Outputs come only from registers, so TREADY never reaches TVALID.
  always_comb begin
    m_axis.tvalid = (state_q == SEND);
    m_axis.tlast  = (state_q == SEND) && (beat_q == LAST_BEAT);
    m_axis.tstrb  = '1;
    BUSY          = (state_q == SEND);
    m_axis.tdata  = '0;
    if (state_q == SEND) begin
      unique case (mode_q)
        2'd0: m_axis.tdata = base_q;
        2'd1: m_axis.tdata = base_q + DATA_WIDTH'(beat_q);
        2'd2: m_axis.tdata = DATA_WIDTH'(beat_q);
        2'd3: m_axis.tdata = ~base_q;
        default: m_axis.tdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_pattern_gen.sv
// Directed bench for axis_frame_pattern_gen: period-10 and period-4 instances
// with hand-computed beat values, stall, overrun, reset and stop scenarios.
module tb_axis_frame_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, busy_a;
  logic [1:0]  mode_a;
  logic [15:0] fc_a, mc_a;
  logic        rst_b, start_b, busy_b;
  logic [1:0]  mode_b;
  logic [15:0] fc_b, mc_b;

  axis_frame_pattern_gen_if #(.DATA_WIDTH(8)) axis_a ();
  axis_frame_pattern_gen_if #(.DATA_WIDTH(8)) axis_b ();

  axis_frame_pattern_gen #(
    .DATA_WIDTH(8), .FRAME_BEATS(4), .PERIOD_CYCLES(10),
    .INIT_VALUE(4), .FRAME_STEP(2), .STAT_WIDTH(16)
  ) dut_a (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst_a), .START(start_a), .MODE(mode_a),
    .m_axis(axis_a), .BUSY(busy_a), .FRAME_COUNT(fc_a), .MISSED_COUNT(mc_a)
  );

  axis_frame_pattern_gen #(
    .DATA_WIDTH(8), .FRAME_BEATS(4), .PERIOD_CYCLES(4),
    .INIT_VALUE(4), .FRAME_STEP(2), .STAT_WIDTH(16)
  ) dut_b (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst_b), .START(start_b), .MODE(mode_b),
    .m_axis(axis_b), .BUSY(busy_b), .FRAME_COUNT(fc_b), .MISSED_COUNT(mc_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    start_a = 1'b0;
    axis_a.tready = 1'b1;
    step();
    step();
    rst_a = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_cycles);
    int n = 0;
    while (!axis_a.tvalid && n < 40) begin
      step();
      n++;
    end
    check_eq(tag, n, exp_cycles);
  endtask

  // Expects beat 0 on the bus now, TREADY high; leaves just after the last transfer.
  task automatic expect_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_valid"}, axis_a.tvalid, 1);
      check_eq({tag, "_data"}, axis_a.tdata, e[k]);
      check_eq({tag, "_last"}, axis_a.tlast, (k == 3) ? 1 : 0);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_b = 1'b1; start_b = 1'b0; mode_b = 2'd0; axis_b.tready = 1'b1;
    mode_a = 2'd0;

    // Reset values and MODE 0 with stepped base
    do_reset();
    check_eq("rst_tvalid", axis_a.tvalid, 0);
    check_eq("rst_tlast", axis_a.tlast, 0);
    check_eq("rst_tdata", axis_a.tdata, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_fc", fc_a, 0);
    check_eq("rst_mc", mc_a, 0);
    check_eq("tstrb", axis_a.tstrb, 8'h1);
    start_a = 1'b1; mode_a = 2'd0;
    check_eq("m0_prelaunch", axis_a.tvalid, 0);
    step();
    check_eq("m0_busy", busy_a, 1);
    expect_frame("m0_f1", 4, 4, 4, 4);
    check_eq("m0_idle_valid", axis_a.tvalid, 0);
    check_eq("m0_idle_busy", busy_a, 0);
    check_eq("m0_fc1", fc_a, 1);
    wait_valid("m0_gap", 6);
    expect_frame("m0_f2", 6, 6, 6, 6);
    check_eq("m0_fc2", fc_a, 2);
    check_eq("m0_mc", mc_a, 0);

    // MODE 1 ramp and base wrap 254 -> 0 -> 2
    do_reset();
    start_a = 1'b1; mode_a = 2'd1;
    step();
    expect_frame("m1_f1", 4, 5, 6, 7);
    wait_valid("m1_gap", 6);
    expect_frame("m1_f2", 6, 7, 8, 9);
    for (int f = 2; f < 128; f++) begin
      wait_valid("wrap_gap", 6);
      if (f == 125) check_eq("wrap_254", axis_a.tdata, 254);
      if (f == 126) check_eq("wrap_0", axis_a.tdata, 0);
      if (f == 127) check_eq("wrap_2", axis_a.tdata, 2);
      repeat (4) step();
    end
    check_eq("wrap_fc", fc_a, 128);

    // Backpressure on beat 2
    do_reset();
    start_a = 1'b1; mode_a = 2'd1;
    step();
    check_eq("stall_b0", axis_a.tdata, 4);
    step();
    check_eq("stall_b1", axis_a.tdata, 5);
    step();
    axis_a.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_valid", axis_a.tvalid, 1);
      check_eq("stall_data", axis_a.tdata, 6);
      check_eq("stall_last", axis_a.tlast, 0);
      step();
    end
    axis_a.tready = 1'b1;
    check_eq("stall_b2", axis_a.tdata, 6);
    step();
    check_eq("stall_b3", axis_a.tdata, 7);
    check_eq("stall_b3_last", axis_a.tlast, 1);
    step();
    check_eq("stall_done", axis_a.tvalid, 0);
    check_eq("stall_fc", fc_a, 1);

    // Long stall: ticks at +10 and +20 are missed
    do_reset();
    axis_a.tready = 1'b0; start_a = 1'b1; mode_a = 2'd0;
    step();
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (axis_a.tvalid !== 1'b1 || axis_a.tdata !== 8'd4) bad++;
    end
    check_eq("miss_hold", bad, 0);
    axis_a.tready = 1'b1;
    expect_frame("miss_frame", 4, 4, 4, 4);
    start_a = 1'b0;
    check_eq("miss_mc", mc_a, 2);
    check_eq("miss_fc", fc_a, 1);
    check_eq("miss_idle", axis_a.tvalid, 0);

    // Back-to-back frames at PERIOD_CYCLES == FRAME_BEATS
    check_eq("b2b_rst_valid", axis_b.tvalid, 0);
    rst_b = 1'b0; start_b = 1'b1; mode_b = 2'd1;
    step();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("b2b_valid", axis_b.tvalid, 1);
        check_eq("b2b_data", axis_b.tdata, 4 + 2 * f + k);
        check_eq("b2b_last", axis_b.tlast, (k == 3) ? 1 : 0);
        step();
      end
    end
    check_eq("b2b_fc", fc_b, 3);
    check_eq("b2b_mc", mc_b, 0);
    check_eq("b2b_still_valid", axis_b.tvalid, 1);
    start_b = 1'b0;

    // Reset mid-frame
    do_reset();
    start_a = 1'b1; mode_a = 2'd1;
    step();
    expect_frame("rmid_f1", 4, 5, 6, 7);
    wait_valid("rmid_gap", 6);
    step();
    check_eq("rmid_b1", axis_a.tdata, 7);
    rst_a = 1'b1;
    step();
    check_eq("rmid_valid", axis_a.tvalid, 0);
    check_eq("rmid_last", axis_a.tlast, 0);
    check_eq("rmid_data", axis_a.tdata, 0);
    check_eq("rmid_busy", busy_a, 0);
    check_eq("rmid_fc", fc_a, 0);
    check_eq("rmid_mc", mc_a, 0);
    rst_a = 1'b0;
    step();
    check_eq("rmid_restart_valid", axis_a.tvalid, 1);
    check_eq("rmid_restart_data", axis_a.tdata, 4);

    // START dropped mid-frame
    do_reset();
    start_a = 1'b1; mode_a = 2'd1;
    step();
    step();
    start_a = 1'b0;
    check_eq("stop_b1", axis_a.tdata, 5);
    step();
    check_eq("stop_b2", axis_a.tdata, 6);
    step();
    check_eq("stop_b3", axis_a.tdata, 7);
    check_eq("stop_b3_last", axis_a.tlast, 1);
    step();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (axis_a.tvalid !== 1'b0 || busy_a !== 1'b0) bad++;
      step();
    end
    check_eq("stop_quiet", bad, 0);
    check_eq("stop_fc", fc_a, 1);

    // MODE 3 inverse base; MODE change mid-frame applies at next launch (MODE 2)
    start_a = 1'b1; mode_a = 2'd3;
    step();
    mode_a = 2'd2;
    expect_frame("m3_frame", 8'd249, 8'd249, 8'd249, 8'd249);
    wait_valid("m2_gap", 6);
    expect_frame("m2_frame", 0, 1, 2, 3);
    start_a = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
